oam_dma_engine: RTL
===================

Name: oam_dma_engine

Overview:
Bus initiator for Game Boy OAM DMA. A CPU write to the FF46 register starts a copy of NBYTES bytes from source page {src_hi, 8'h00} into OAM.
- Reads use the combinational memory read port (addr + rd_cs, data returned same cycle on rd_data).
- Writes use the clocked OAM write port (wr_data + wr_cs, captured on clock edge).
- Sits between the system memory map and the OAM instance; reports busy so the bus arbiter can block CPU accesses.

Parameters:
ASZ, 16, source address width
NBYTES, 160, bytes copied per transfer (1..256)
START_DLY, 4, clocks between trigger and first read
BYTE_CYCLES, 4, clocks per byte (must be >= 3)

Ports:
clk  input  1  system clock (also drives OAM wr_clk)
rst  input  1  synchronous reset, active-high
reg_wr  input  1  one-clock strobe: CPU write to FF46
reg_wdata  input  8  source high byte from CPU
dma_reg  output  8  readback value of FF46 (last written)
src_addr  output  ASZ  source memory address
src_rd_cs  output  1  source read chip-select
src_rd_data  input  8  source read data (combinational, valid while src_rd_cs high)
oam_addr  output  8  OAM write address
oam_wr_data  output  8  OAM write data
oam_wr_cs  output  1  OAM write enable, sampled on clk rising edge
busy  output  1  transfer in progress (START or COPY)

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous and active-high.
- Reset values: dma_reg=8'hFF; src_addr=0; src_rd_cs=0; oam_addr=0; oam_wr_data=0; oam_wr_cs=0; busy=0; state=IDLE; counters=0.
- States:
  - IDLE: all strobes low. reg_wr -> START.
  - START: delay counter runs 0..START_DLY-1, then -> COPY with idx=0, phase=0.
  - COPY: phase counter runs 0..BYTE_CYCLES-1 per byte.
    - phase 0 and 1: src_addr={hi,idx}, src_rd_cs=1.
    - End of phase 1: latch src_rd_data into oam_wr_data.
    - phase 2: oam_addr=idx, oam_wr_cs=1 for exactly one clock.
    - phases 3..BYTE_CYCLES-1: idle.
    - On the last phase: if idx==NBYTES-1 -> IDLE, else idx++.
- Trigger latency: reg_wr sampled at edge N sets dma_reg=reg_wdata and busy=1 after edge N.
- Busy duration: busy stays high for exactly START_DLY + NBYTES*BYTE_CYCLES clocks and falls after the edge that completes the last phase.
- Transfer timing: first src_rd_cs at clock START_DLY after trigger. First oam_wr_cs at START_DLY+2.
- Address formation: idx is 8 bits and never wraps past NBYTES-1. src_addr upper bits come from the hi byte captured at trigger; changes to dma_reg only take effect on a new trigger.
- Retrigger: reg_wr while busy aborts the current copy immediately.
  - Strobes drop next clock.
  - A write pending in phase 2 of that same cycle still completes.
  - Restarts in START with the new hi byte and idx=0.
  - Bytes already written stay in OAM.
- Mid-transfer reset: reset mid-transfer returns to IDLE next edge with all strobes low. OAM contents are untouched.
- Simultaneous rst and reg_wr: rst wins. dma_reg=FF, no transfer.
- Strobe exclusivity: src_rd_cs and oam_wr_cs are never high in the same clock.

Optional Feature:
Macro: OAM_DMA_ECHO_MAP_EN
- Defined: captured hi byte 8'hE0..8'hFF maps to hi-8'h20, so the source reads echo-RAM-backed WRAM C000..DFFF. dma_reg still reads back the unmapped written value.
- Undefined: hi byte is used as-is for all values.

Test Plan:
- Basic copy: preload source C000..C09F with idx^8'h5A; pulse reg_wr with 8'hC0 -> busy high 644 clocks; OAM[i]=i^8'h5A for i=0..159; exactly 160 oam_wr_cs pulses; dma_reg=8'hC0.
- Timing: trigger at clock 0 -> src_rd_cs first high at clock 4 with src_addr=16'hC000; oam_wr_cs at clock 6 with oam_addr=0; last oam_wr_cs at clock 642, oam_addr=159.
- Retrigger: trigger 8'hC0, then 8'hD0 at byte 50 phase 0 -> OAM[0..49] from C0xx; restart with 4-clock delay; final OAM[0..159] from D000..D09F; busy drops 644 clocks after the second write.
- Reset mid-transfer: assert rst at byte 80 -> next clock: busy=0, strobes=0, dma_reg=FF; no further OAM writes; OAM[0..79] preserved.
- Echo mapping: write 8'hE1 -> with OAM_DMA_ECHO_MAP_EN, src_addr starts 16'hC100; without it, starts 16'hE100; dma_reg=8'hE1 in both builds.
- rst and reg_wr in the same cycle -> no busy, dma_reg=8'hFF; an idle reg_wr with 8'h00 -> copy from 0000..009F.

Source files
------------

// File: rtl/oam_dma_engine_if.sv
// Source-read and OAM-write bus bundle for the OAM DMA engine.
// master = DMA initiator, slave = memory map / OAM side.
interface oam_dma_engine_if #(
  parameter int ASZ = 16
);
  logic [ASZ-1:0] src_addr;
  logic           src_rd_cs;
  logic [7:0]     src_rd_data;
  logic [7:0]     oam_addr;
  logic [7:0]     oam_wr_data;
  logic           oam_wr_cs;

  modport master (
    output src_addr,
    output src_rd_cs,
    input  src_rd_data,
    output oam_addr,
    output oam_wr_data,
    output oam_wr_cs
  );

  modport slave (
    input  src_addr,
    input  src_rd_cs,
    output src_rd_data,
    input  oam_addr,
    input  oam_wr_data,
    input  oam_wr_cs
  );
endinterface

// File: rtl/oam_dma_engine.sv
// Game Boy OAM DMA initiator: FF46 write copies NBYTES from {hi,00} into OAM.
// Optional OAM_DMA_ECHO_MAP_EN folds E0..FF source pages onto C0..DF.
module oam_dma_engine #(
  parameter int ASZ         = 16,
  parameter int NBYTES      = 160,
  parameter int START_DLY   = 4,
  parameter int BYTE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_wr,
  input  logic [7:0]         reg_wdata,
  output logic [7:0]         dma_reg,
  output logic               busy,
  oam_dma_engine_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_COPY
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] dly_q, dly_d;
  logic [15:0] ph_q, ph_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  hi_map;
  logic [15:0] addr16;
  logic        in_copy;

  // Source page translation applied once, when the trigger is captured.
`ifdef OAM_DMA_ECHO_MAP_EN
  always_comb begin
    hi_map = reg_wdata;
    if (reg_wdata >= 8'hE0) hi_map = reg_wdata - 8'h20;
  end
`else
  always_comb hi_map = reg_wdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      ph_q    <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      reg_q   <= 8'hFF;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    ph_d    = ph_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    reg_d   = reg_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: ;
      S_START: begin
        if (dly_q == 16'(START_DLY - 1)) begin
          state_d = S_COPY;
          dly_d   = '0;
          ph_d    = '0;
          idx_d   = '0;
        end else begin
          dly_d = dly_q + 16'd1;
        end
      end
      S_COPY: begin
        if (ph_q == 16'd1) data_d = bus.src_rd_data;
        if (ph_q == 16'(BYTE_CYCLES - 1)) begin
          ph_d = '0;
          if (idx_q == 8'(NBYTES - 1)) state_d = S_IDLE;
          else idx_d = idx_q + 8'd1;
        end else begin
          ph_d = ph_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new trigger aborts whatever is running; strobes are
    // decoded from state, so a phase-2 write this cycle still lands.
    if (reg_wr) begin
      reg_d   = reg_wdata;
      hi_d    = hi_map;
      state_d = S_START;
      dly_d   = '0;
      ph_d    = '0;
      idx_d   = '0;
    end
  end

  assign in_copy         = (state_q == S_COPY);
  assign addr16          = {hi_q, idx_q};
  assign bus.src_addr    = ASZ'(addr16);
  assign bus.src_rd_cs   = in_copy && (ph_q < 16'd2);
  assign bus.oam_wr_cs   = in_copy && (ph_q == 16'd2);
  assign bus.oam_addr    = idx_q;
  assign bus.oam_wr_data = data_q;
  assign busy            = (state_q != S_IDLE);
  assign dma_reg         = reg_q;

endmodule
